// File: rtl/inst_axi_bridge.sv
// inst_axi_bridge
// Converts the instruction-fetch SRAM-like bus (req / addr_ok / data_ok) into
// single-beat AXI4 read transactions. Only one request is outstanding at a time:
// accept -> AR handshake -> R handshake -> one inst_data_ok pulse.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   inst_req/wr/size/addr    SRAM-like request side (inst_wdata unused)
//   inst_addr_ok             request accepted this cycle (IDLE only)
//   inst_data_ok/inst_rdata  one-cycle completion pulse with returned word
//   bus_err                  error flag, pulses together with inst_data_ok
//   ar*                      AXI4 read address channel (single beat, INCR)
//   r*                       AXI4 read data channel (rid/rlast not checked)
module inst_axi_bridge #(
    parameter logic [3:0] ARID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    output logic        bus_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] buf_q, buf_d;
    logic        err_q, err_d;
    logic        accept;

    // Write data, response ID and rlast carry no information for this bridge.
    logic unused_inputs;
    assign unused_inputs = ^{inst_wdata, rid, rlast};

    // rst is folded in so addr_ok is never seen high while reset is asserted.
    assign accept = (state_q == S_IDLE) & inst_req & ~rst;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            buf_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = inst_wr ? S_DONE : S_AR;
            S_AR:   if (arready) state_d = S_R;
            S_R:    if (rvalid) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: request latch and response buffer
    always_comb begin
        addr_d = addr_q;
        size_d = size_q;
        buf_d  = buf_q;
        err_d  = err_q;
        if (accept) begin
            if (inst_wr) begin
                // Writes are not supported: complete locally with zero data and an error.
                buf_d = 32'd0;
                err_d = 1'b1;
            end else begin
                addr_d = inst_addr;
                size_d = inst_size;
            end
        end else if ((state_q == S_R) && rvalid) begin
            buf_d = rdata;
            err_d = (rresp != 2'b00);
        end
    end

    // Outputs
    always_comb begin
        inst_addr_ok = accept;
        arvalid      = (state_q == S_AR);
        rready       = (state_q == S_R);
        inst_data_ok = (state_q == S_DONE);
        bus_err      = (state_q == S_DONE) & err_q;
    end

    assign inst_rdata = buf_q;
    assign araddr     = addr_q;
    assign arsize     = {1'b0, size_q};
    assign arlen      = 8'd0;
    assign arburst    = 2'b01;
    assign arid       = ARID;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Scoreboard bench for inst_axi_bridge: expected completions and AR beats are
// queued when requests are issued; a negedge monitor pops and compares.
module tb_inst_axi_bridge;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        bus_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic        auto_data;
    logic [31:0] rdata_v;

    inst_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    // Slave data model: in auto mode the returned word is derived from the
    // address being read, so reordering or stale data is visible.
    assign rdata = auto_data ? (araddr ^ 32'h5A5A_0000) : rdata_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; logic err; } exp_t;
    typedef struct { logic [31:0] addr; logic [2:0] size; } ar_t;
    exp_t exp_q[$];
    ar_t  ar_q[$];
    int   dok_times[$];

    int n_chk = 0;
    int n_fail = 0;
    int dok_cnt = 0;
    int dok_cyc = 0;
    int arv_cnt = 0;
    int exp_dok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    logic        prev_arv = 1'b0;
    logic        prev_arr = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    always @(negedge clk) begin
        if (!rst) begin
            if (inst_data_ok) begin
                dok_cnt++;
                dok_cyc = cyc;
                dok_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_data_ok", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("inst_rdata", inst_rdata, e.data);
                    chk("bus_err", 32'(bus_err), 32'(e.err));
                end
            end
            if (bus_err) chk("bus_err_without_data_ok", 32'(inst_data_ok), 32'd1);
            if (arvalid) arv_cnt++;
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    chk("unexpected_ar", 32'd1, 32'd0);
                end else begin
                    ar_t a;
                    a = ar_q.pop_front();
                    chk("araddr", araddr, a.addr);
                    chk("arsize", 32'(arsize), 32'(a.size));
                    chk("arlen", 32'(arlen), 32'd0);
                    chk("arburst", 32'(arburst), 32'd1);
                    chk("arid", 32'(arid), 32'd0);
                end
            end
            if (inst_addr_ok)
                chk("addr_ok_outside_idle", 32'({arvalid, rready, inst_data_ok}), 32'd0);
            if (prev_arv && !prev_arr) begin
                chk("arvalid_hold", 32'(arvalid), 32'd1);
                chk("araddr_stable", araddr, prev_addr);
            end
            prev_arv  = arvalid;
            prev_arr  = arready;
            prev_addr = araddr;
        end else begin
            prev_arv = 1'b0;
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);
        exp_dok++;
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [2:0] s);
        ar_t x;
        x.addr = a;
        x.size = s;
        ar_q.push_back(x);
    endtask

    // Present a request (called just after a posedge), return the accept cycle,
    // and drop the request one cycle after acceptance.
    task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic w, output int acc);
        bit ok;
        ok = 1'b0;
        inst_req  = 1'b1;
        inst_addr = a;
        inst_size = s;
        inst_wr   = w;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (inst_addr_ok) ok = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        acc = cyc;
        chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        inst_req = 1'b0;
        inst_wr  = 1'b0;
    endtask

    task automatic wait_dok(input string name);
        for (int i = 0; i < 100 && dok_cnt < exp_dok; i++) @(posedge clk);
        #1;
        chk(name, 32'(dok_cnt >= exp_dok), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, rh, a0, base, k;
        bit ok;
        rst = 1'b1;
        inst_req = 1'b1;       // request present during reset must not be accepted
        inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h1234_5678; inst_wdata = 32'hFFFF_FFFF;
        arready = 1'b0; rvalid = 1'b0; rid = 4'd0; rresp = 2'b00; rlast = 1'b1;
        auto_data = 1'b0; rdata_v = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("rst_rdata", inst_rdata, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arsize", 32'(arsize), 32'd0);
        @(posedge clk); #1;
        inst_req = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single read, zero latency
        arready = 1'b1; rvalid = 1'b1; rdata_v = 32'h3C1D_8000; rresp = 2'b00;
        push_exp(32'h3C1D_8000, 1'b0);
        push_ar(32'hBFC0_0000, 3'b010);
        issue(32'hBFC0_0000, 2'd2, 1'b0, c);
        @(negedge clk);
        chk("t1_arvalid_cycle1", 32'(arvalid), 32'd1);
        chk("t1_araddr_cycle1", araddr, 32'hBFC0_0000);
        chk("t1_arsize_cycle1", 32'(arsize), 32'd2);
        wait_dok("t1_dok_timeout");
        chk("t1_dok_cycle", 32'(dok_cyc), 32'(c + 3));
        repeat (2) @(posedge clk); #1;

        // Backpressure: arready low 5 cycles, rvalid delayed 7 cycles
        arready = 1'b0; rvalid = 1'b0; rdata_v = 32'h1234_5678;
        push_exp(32'h1234_5678, 1'b0);
        push_ar(32'h0000_1000, 3'b010);
        issue(32'h0000_1000, 2'd2, 1'b0, c);
        repeat (4) @(posedge clk); #1;
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        repeat (6) @(posedge clk); #1;
        @(negedge clk);
        chk("t2_rready_waiting", 32'(rready), 32'd1);
        @(posedge clk); #1;
        rvalid = 1'b1;
        rh = cyc;
        @(posedge clk); #1;
        rvalid = 1'b0;
        wait_dok("t2_dok_timeout");
        chk("t2_dok_after_r", 32'(dok_cyc), 32'(rh + 1));
        repeat (5) @(posedge clk); #1;
        chk("t2_single_dok", 32'(dok_cnt), 32'd2);

        // Back-to-back with inst_req held high
        arready = 1'b1; rvalid = 1'b1; auto_data = 1'b1; rresp = 2'b00;
        dok_times.delete();
        for (int i = 0; i < 3; i++) begin
            push_exp(32'(i * 4) ^ 32'h5A5A_0000, 1'b0);
            push_ar(32'(i * 4), 3'b010);
        end
        inst_req = 1'b1; inst_size = 2'd2; inst_wr = 1'b0;
        k = 0;
        for (int i = 0; i < 40 && k < 3; i++) begin
            inst_addr = 32'(k * 4);
            @(negedge clk);
            if (inst_addr_ok) k++;
            @(posedge clk); #1;
        end
        inst_req = 1'b0;
        chk("t3_accepts", 32'(k), 32'd3);
        wait_dok("t3_dok_timeout");
        chk("t3_dok_count", 32'(dok_times.size()), 32'd3);
        if (dok_times.size() == 3) begin
            chk("t3_spacing_1", 32'(dok_times[1] - dok_times[0]), 32'd4);
            chk("t3_spacing_2", 32'(dok_times[2] - dok_times[1]), 32'd4);
        end
        auto_data = 1'b0;
        repeat (2) @(posedge clk); #1;

        // SLVERR response
        rdata_v = 32'hDEAD_BEEF; rresp = 2'b10;
        push_exp(32'hDEAD_BEEF, 1'b1);
        push_ar(32'h0000_0040, 3'b010);
        issue(32'h0000_0040, 2'd2, 1'b0, c);
        wait_dok("t4_dok_timeout");
        chk("t4_dok_cycle", 32'(dok_cyc), 32'(c + 3));
        rresp = 2'b00;
        repeat (2) @(posedge clk); #1;

        // Unsupported write
        arready = 1'b0; rvalid = 1'b0;
        a0 = arv_cnt;
        push_exp(32'd0, 1'b1);
        issue(32'h0000_0080, 2'd2, 1'b1, c);
        wait_dok("t5_dok_timeout");
        chk("t5_dok_cycle", 32'(dok_cyc), 32'(c + 1));
        repeat (3) @(posedge clk); #1;
        chk("t5_no_arvalid", 32'(arv_cnt), 32'(a0));

        // Reset while in R, then a normal read
        arready = 1'b1; rvalid = 1'b0;
        push_ar(32'h0000_2000, 3'b010);
        issue(32'h0000_2000, 2'd2, 1'b0, c);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rready) ok = 1'b1;
        end
        chk("t6_reach_r", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rready_rst", 32'(rready), 32'd0);
        chk("t6_arvalid_rst", 32'(arvalid), 32'd0);
        chk("t6_data_ok_rst", 32'(inst_data_ok), 32'd0);
        chk("t6_rdata_rst", inst_rdata, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        base = dok_cnt;
        rvalid = 1'b1; rdata_v = 32'hCAFE_F00D;
        push_exp(32'hCAFE_F00D, 1'b0);
        push_ar(32'h0000_3000, 3'b000);
        issue(32'h0000_3000, 2'd0, 1'b0, c);
        wait_dok("t6_dok_timeout");
        chk("t6_dok_cycle", 32'(dok_cyc), 32'(c + 3));
        chk("t6_one_dok", 32'(dok_cnt - base), 32'd1);
        repeat (3) @(posedge clk); #1;

        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("ar_queue_drained", 32'(ar_q.size()), 32'd0);
        chk("total_data_ok", 32'(dok_cnt), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_axi_bridge.md
# inst_axi_bridge

Converts the fetch-side SRAM-like bus (req / addr_ok / data_ok) into single-beat AXI4 read transactions. It sits directly downstream of the instruction SRAM-like adapter and upstream of the system AXI interconnect. It is a single-outstanding, non-pipelined bridge: one request is accepted, issued on AR, completed on R, and returned as one `inst_data_ok` pulse.

## Interface
Parameters:
- ARID, 4'd0, constant value driven on `arid`

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- inst_req  in  1  SRAM-like request valid
- inst_wr  in  1  1 = write (unsupported, see Operation)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  request byte address
- inst_wdata  in  32  ignored
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  one-cycle pulse, `inst_rdata` valid
- inst_rdata  out  32  returned instruction word
- bus_err  out  1  one-cycle pulse, coincident with `inst_data_ok`, on error completion
- arid  out  4  = ARID
- araddr  out  32  latched request address
- arlen  out  8  constant 8'd0
- arsize  out  3  {1'b0, latched inst_size}
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  not checked
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  not checked; every accepted beat is final
- rvalid  in  1  R valid
- rready  out  1  R ready

## Operation
- FSM states: IDLE, AR, R, DONE. Reset state IDLE.
- IDLE: `inst_addr_ok = inst_req & ~rst`. On `inst_req & inst_addr_ok`:
  - `inst_wr=0` → latch `inst_addr`, `inst_size`, go AR.
  - `inst_wr=1` → no AXI traffic; latch rdata buffer = 0, set err flag, go DONE.
- AR: `arvalid=1`; `araddr` and `arsize` stable from latched copies. On `arready` → R. `arvalid` never drops before `arready`.
- R: `rready=1`. On `rvalid` → latch `rdata` into buffer, latch err = (`rresp != 2'b00`), go DONE.
- DONE: `inst_data_ok=1`, `inst_rdata` = buffer, `bus_err` = err flag; next state IDLE unconditionally.
- `inst_addr_ok` is 0 in AR, R, DONE; a new request is never accepted while one is in flight.
- `inst_rdata` holds the last buffer value outside DONE; upstream must sample only on `inst_data_ok`.
- Error completions (SLVERR/DECERR, unsupported write) still return data (`rdata` or 0) and complete normally. No retry.

## Timing
- Reset values: `inst_addr_ok`=0, `inst_data_ok`=0, `inst_rdata`=0, `bus_err`=0, `arvalid`=0, `rready`=0, `araddr`=0, `arsize`=0. Asserting `rst` at any state returns to IDLE asynchronously. An in-flight AXI transaction is abandoned; the interconnect is reset in the same domain.
- Accept at cycle 0 → `arvalid` high at cycle 1.
- `arready` at cycle a → `rready` high at a+1.
- `rvalid` at cycle r → `inst_data_ok` at r+1 → `inst_addr_ok` possible at r+2.
- Minimum round trip with `arready` and `rvalid` always high: accept 0, AR 1, R 2, DONE 3, next accept 4.
- Unsupported write: accept 0, DONE 1, next accept 2.
- `inst_req` held high through DONE is not re-accepted until IDLE, so each accept yields exactly one `inst_data_ok`.
- `rvalid` asserted while in IDLE or AR is not consumed (`rready`=0).

## Test plan
- Reset then single read: `inst_addr`=0xBFC00000, size 2; `arready`/`rvalid` always 1, `rdata`=0x3C1D8000, `rresp`=0.
  → `araddr`=0xBFC00000, `arsize`=3'b010, `arlen`=0, `arburst`=01 at cycle 1; `inst_data_ok`=1 with `inst_rdata`=0x3C1D8000 at cycle 3; `bus_err`=0.
- Backpressure: `arready` low 5 cycles, then `rvalid` delayed 7 cycles.
  → `arvalid` and `araddr` stable throughout; exactly one `inst_data_ok`, 1 cycle after the R handshake.
- Back-to-back requests, `inst_req` held high with addresses 0x0, 0x4, 0x8.
  → three AR transactions in order; `inst_addr_ok` never high outside IDLE; 3 `data_ok` pulses, 4-cycle spacing at zero latency.
- `rresp`=2'b10 with `rdata`=0xDEADBEEF.
  → `inst_data_ok`=1, `inst_rdata`=0xDEADBEEF, `bus_err`=1 in the same cycle.
- `inst_wr`=1 request.
  → no `arvalid`; `inst_data_ok` and `bus_err` at cycle 1; `inst_rdata`=0.
- `rst` pulsed mid-transaction while in R state.
  → `rready`, `arvalid`, `inst_data_ok` go 0 immediately; after release, the next request completes normally.
